alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (0: decode/execute path,
//  1: auxiliary unit, e.g. address-generation or debug). Round-robin arbitration,
//  valid/ready handshakes on request and response sides, registered operands and results.
//  Sits between the requesters and the ALU instance; the ALU is driven only by this block.
// PARAMETERS
//  DATA_W    32  operand/result width (matches ALU A/B/Result)
//  PRIO_INIT 0   requester holding priority after reset (0 or 1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-low reset
//  req_valid    in   2       per-requester request valid
//  req_ready    out  2       per-requester request accept (one-hot or 0)
//  req0_a/req1_a in  DATA_W  operand A per requester
//  req0_b/req1_b in  DATA_W  operand B per requester
//  req0_op/req1_op in 3      ALUcontrol code per requester
//  alu_a        out  DATA_W  to ALU A
//  alu_b        out  DATA_W  to ALU B
//  alu_ctrl     out  3       to ALU ALUcontrol
//  alu_result   in   DATA_W  from ALU Result
//  alu_flags    in   4       from ALU {Z_F,N_F,V_F,C_F}
//  rsp_valid    out  2       per-requester response valid (one-hot or 0)
//  rsp_ready    in   2       per-requester response accept
//  rsp_result   out  DATA_W  registered result (shared by both channels)
//  rsp_flags    out  4       registered {Z,N,V,C}
//  rsp_err      out  1       illegal-op indication (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0,
//    alu_a/alu_b/alu_ctrl=0, operand regs=0, grant=0, prio=PRIO_INIT. Async reset
//    mid-transaction drops the transaction; rsp_valid falls immediately, no replay.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: req_ready combinational; winner = prio if req_valid[prio] else the other.
//    req_ready[winner]=1 only if req_valid[winner]; loser ready=0. On handshake latch
//    a/b/op and grant=winner, go EXEC. No valid -> stay IDLE, ready=0.
//  - EXEC (1 cycle): alu_a/b/ctrl driven from operand regs (held stable entire cycle);
//    capture alu_result/alu_flags into rsp regs at cycle end, go RESP.
//  - RESP: rsp_valid[grant]=1, rsp_result/flags/err stable until rsp_ready[grant];
//    on handshake go IDLE, prio <= ~grant. rsp_ready on non-granted channel ignored.
//  - Latency: request handshake at edge T -> rsp_valid high after edge T+2 (min 3 cycles
//    per op, no overlap; throughput 1 op / 3 cycles with rsp_ready held high).
//  - Both valid: priority holder wins; after completion the other wins next. Single valid:
//    granted regardless of prio; prio still flips to non-served requester.
//  - Requester may deassert req_valid before acceptance; no state change results.
//  - alu_* outputs hold last value outside EXEC (no toggling when idle).
//  - Flags passed unchanged from ALU; no arithmetic in this block.
// CONFIGURATION
//  ALU_ARB_ILLEGAL_OP_EN defined: ops 3'b100, 3'b110, 3'b111 are illegal. Accepted
//    normally, but EXEC is skipped (IDLE -> RESP), ALU not driven, rsp_result=0,
//    rsp_flags=4'b1000, rsp_err=1; latency 2 cycles. Legal ops give rsp_err=0.
//  Not defined: all eight codes sent to ALU unchanged; rsp_err tied 0.
// TESTING
//  1 req0: op=000 a=5 b=3 -> rsp_valid=01 after 2 edges, result=8, flags=0000.
//  2 req1: op=001 a=3 b=5 -> result=0xFFFFFFFE, flags N=1 C=0; then op=001 a=7 b=7 ->
//    result=0, Z=1 C=1.
//  3 req0 op=000 a=0x7FFFFFFF b=1 -> result=0x80000000, N=1 V=1.
//  4 both valid continuously, PRIO_INIT=0, rsp_ready=11 -> grants 0,1,0,1; each 3 cycles.
//  5 rsp_ready low 5 cycles -> rsp_valid/result stable, req_ready=00 throughout; assert
//    rst low in RESP -> rsp_valid=0 same cycle, state IDLE, prio=PRIO_INIT.
//  6 op=111: with ALU_ARB_ILLEGAL_OP_EN rsp_err=1, result=0, latency 2; without,
//    result=ALU output (0), rsp_err=0, latency 3.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU.
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN (reject ops 100/110/111 without using the ALU).
module alu_arbiter #(
    parameter int DATA_W    = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req0_op,
    input  logic [2:0]        req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [1:0]        dbg_state,
    output logic              dbg_grant,
    output logic              dbg_prio
);

    // Handshake rule on both sides: a transfer happens on a rising edge where
    // valid and ready are both high; ready never depends on itself.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                prio_q, prio_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;

    logic                winner;
    logic [DATA_W-1:0]   win_a;
    logic [DATA_W-1:0]   win_b;
    logic [2:0]          win_op;
    logic                accept;
    logic                illegal;

    // Arbitration: the priority holder wins if it asks, otherwise the other side.
    always_comb begin
        winner    = req_valid[prio_q] ? prio_q : ~prio_q;
        win_a     = winner ? req1_a  : req0_a;
        win_b     = winner ? req1_b  : req0_b;
        win_op    = winner ? req1_op : req0_op;
        accept    = (state_q == S_IDLE) && rst && req_valid[winner];
        req_ready = 2'b00;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
`ifdef ALU_ARB_ILLEGAL_OP_EN
        illegal = (win_op == 3'b100) || (win_op == 3'b110) || (win_op == 3'b111);
`else
        illegal = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        prio_d       = prio_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d = winner;
                    if (illegal) begin
                        // ALU registers keep their old value so the ALU sees no activity.
                        state_d      = S_RESP;
                        rsp_result_d = '0;
                        rsp_flags_d  = 4'b1000;
                        rsp_err_d    = 1'b1;
                    end else begin
                        state_d    = S_EXEC;
                        alu_a_d    = win_a;
                        alu_b_d    = win_b;
                        alu_ctrl_d = win_op;
                    end
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                rsp_err_d    = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) begin
                    state_d = S_IDLE;
                    prio_d  = ~grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            prio_q       <= PRIO_INIT;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            prio_q       <= prio_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Decoded from state so an asynchronous reset drops rsp_valid at once.
    assign rsp_valid  = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign dbg_state  = state_q;
    assign dbg_grant  = grant_q;
    assign dbg_prio   = prio_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: drives both requesters, models the external ALU,
// and checks responses through an expected-value queue.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [1:0]  dbg_state;
    logic        dbg_grant;
    logic        dbg_prio;

    int total = 0;
    int bad   = 0;
    // Entry layout: {channel, err, flags[3:0], result[31:0]}
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_prio(dbg_prio)
    );

    // Reference ALU: returns {Z,N,V,C, result}
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        v, c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = {31'd0, ($signed(a) < $signed(b))};
            3'd6: r = a << b[4:0];
            default: r = '0;
        endcase
        return {(r == 32'd0), r[31], v, c, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

    function automatic logic [37:0] exp_rsp(input logic ch, input logic [31:0] a,
                                            input logic [31:0] b, input logic [2:0] op);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (op == 3'b100 || op == 3'b110 || op == 3'b111) return {ch, 1'b1, 4'b1000, 32'd0};
`endif
        return {ch, 1'b0, alu_model(a, b, op)};
    endfunction

    function automatic int exp_latency(input logic [2:0] op);
        int l;
        l = 2;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (op == 3'b100 || op == 3'b110 || op == 3'b111) l = 1;
`endif
        return l;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (idx == 0) begin req0_a = a; req0_b = b; req0_op = op; end
        else begin req1_a = a; req1_b = b; req1_op = op; end
        req_valid[idx] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (req_ready[idx]) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            exp_q.push_back(exp_rsp(idx[0], a, b, op));
            @(negedge clk);
        end
        req_valid[idx] = 1'b0;
    endtask

    // Leaves the DUT holding the response; lat=1 means valid one edge after acceptance.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, output int lat, output logic [37:0] obs,
                          output bit ok);
        bit ok1;
        send_req(idx, a, b, op, ok1);
        lat = 0; ok = 1'b0; obs = '0;
        if (ok1) begin
            for (int i = 1; i <= 20 && !ok; i++) begin
                if (i > 1) @(negedge clk);
                #1;
                if (rsp_valid === ((idx == 0) ? 2'b01 : 2'b10)) begin
                    ok  = 1'b1;
                    lat = i;
                    obs = {rsp_valid[1], rsp_err, rsp_flags, rsp_result};
                end
            end
        end
    endtask

    task automatic accept_rsp(input int idx);
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready[idx] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        total++; if ({rsp_result, rsp_flags, rsp_err} !== 37'd0) begin bad++; $display("FAIL reset_rsp_regs: got %h/%b/%b want 0", rsp_result, rsp_flags, rsp_err); end
        total++; if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin bad++; $display("FAIL reset_alu_regs: got %h/%h/%b want 0", alu_a, alu_b, alu_ctrl); end
        total++; if ({dbg_state, dbg_grant, dbg_prio} !== 4'b0000) begin bad++; $display("FAIL reset_state: got %b/%b/%b want 0/0/0", dbg_state, dbg_grant, dbg_prio); end
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add_basic();
        int lat; logic [37:0] obs, exp; bit ok;
        run_op(0, 32'd5, 32'd3, 3'b000, lat, obs, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no response want response"); end
        total++; if (lat != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
        total++; if (obs !== {1'b0, 1'b0, 4'b0000, 32'd8}) begin bad++; $display("FAIL basic_const: got %h want %h", obs, {1'b0, 1'b0, 4'b0000, 32'd8}); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (obs !== exp) begin bad++; $display("FAIL basic_sb: got %h want %h", obs, exp); end
        accept_rsp(0);
        #1;
        total++; if (rsp_valid !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL basic_return_idle: got %b/%0d want 00/0", rsp_valid, dbg_state); end
        repeat (2) @(negedge clk);
        total++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, 3'b000}) begin bad++; $display("FAIL basic_alu_hold: got %h/%h/%b want 5/3/000", alu_a, alu_b, alu_ctrl); end
    endtask

    task automatic test_sub_flags();
        int lat; logic [37:0] obs, exp; bit ok;
        run_op(1, 32'd3, 32'd5, 3'b001, lat, obs, ok);
        total++; if (!ok || obs !== {1'b1, 1'b0, 4'b0100, 32'hFFFF_FFFE}) begin bad++; $display("FAIL sub_neg: got %h ok=%0d want %h", obs, ok, {1'b1, 1'b0, 4'b0100, 32'hFFFF_FFFE}); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (obs !== exp) begin bad++; $display("FAIL sub_neg_sb: got %h want %h", obs, exp); end
        accept_rsp(1);
        run_op(1, 32'd7, 32'd7, 3'b001, lat, obs, ok);
        total++; if (!ok || obs !== {1'b1, 1'b0, 4'b1001, 32'd0}) begin bad++; $display("FAIL sub_zero: got %h ok=%0d want %h", obs, ok, {1'b1, 1'b0, 4'b1001, 32'd0}); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (obs !== exp) begin bad++; $display("FAIL sub_zero_sb: got %h want %h", obs, exp); end
        accept_rsp(1);
    endtask

    task automatic test_overflow();
        int lat; logic [37:0] obs, exp; bit ok;
        run_op(0, 32'h7FFF_FFFF, 32'd1, 3'b000, lat, obs, ok);
        total++; if (!ok || obs !== {1'b0, 1'b0, 4'b0110, 32'h8000_0000}) begin bad++; $display("FAIL ovf: got %h ok=%0d want %h", obs, ok, {1'b0, 1'b0, 4'b0110, 32'h8000_0000}); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (obs !== exp) begin bad++; $display("FAIL ovf_sb: got %h want %h", obs, exp); end
        accept_rsp(0);
    endtask

    task automatic test_round_robin();
        int gch[$]; int gcyc[$]; int nrsp; logic ch; logic [37:0] obs, exp;
        do_reset();
        nrsp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin req_valid = 2'b11; rsp_ready = 2'b11; end
            req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 3));
            req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 3));
            #1;
            if (rsp_valid !== 2'b00) begin
                obs = {rsp_valid[1], rsp_err, rsp_flags, rsp_result};
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                nrsp++;
                total++; if (obs !== exp) begin bad++; $display("FAIL rr_sb: got %h want %h", obs, exp); end
            end
            if (req_ready !== 2'b00) begin
                ch = req_ready[1];
                exp_q.push_back(ch ? exp_rsp(1'b1, req1_a, req1_b, req1_op)
                                   : exp_rsp(1'b0, req0_a, req0_b, req0_op));
                gch.push_back(int'(ch));
                gcyc.push_back(c);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        total++; if (gch.size() != 4 || nrsp != 4) begin bad++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 4/4", gch.size(), nrsp); end
        for (int k = 0; k < gch.size(); k++) begin
            total++; if (gch[k] != k % 2) begin bad++; $display("FAIL rr_order: grant %0d got ch%0d want ch%0d", k, gch[k], k % 2); end
            if (k > 0) begin
                total++; if (gcyc[k] - gcyc[k-1] != 3) begin bad++; $display("FAIL rr_spacing: grant %0d got %0d cycles want 3", k, gcyc[k] - gcyc[k-1]); end
            end
        end
    endtask

    task automatic test_stall_reset();
        int lat; logic [37:0] obs, exp; bit ok;
        run_op(0, 32'd10, 32'd20, 3'b011, lat, obs, ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (!ok || obs !== exp) begin bad++; $display("FAIL stall_pre_sb: got %h want %h", obs, exp); end
        accept_rsp(0);
        run_op(1, 32'h0F0F_0000, 32'h00FF_00FF, 3'b010, lat, obs, ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (!ok || obs !== exp) begin bad++; $display("FAIL stall_sb: got %h want %h", obs, exp); end
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            obs = {rsp_valid[1], rsp_err, rsp_flags, rsp_result};
            total++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00 || obs !== exp) begin bad++; $display("FAIL stall_hold: cycle %0d got v=%b rdy=%b %h want v=10 rdy=00 %h", i, rsp_valid, req_ready, obs, exp); end
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin bad++; $display("FAIL rst_in_resp: got v=%b rdy=%b want 00/00", rsp_valid, req_ready); end
        total++; if (dbg_state !== 2'd0 || dbg_prio !== 1'b0) begin bad++; $display("FAIL rst_state: got st=%0d prio=%b want 0/0", dbg_state, dbg_prio); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_prio_init: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_single_prio();
        int lat; logic [37:0] obs, exp; bit ok;
        run_op(0, 32'd1, 32'd1, 3'b000, lat, obs, ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (!ok || obs !== exp) begin bad++; $display("FAIL single_a_sb: got %h want %h", obs, exp); end
        accept_rsp(0);
        #1;
        total++; if (dbg_prio !== 1'b1) begin bad++; $display("FAIL single_prio_flip: got %b want 1", dbg_prio); end
        run_op(0, 32'd9, 32'd2, 3'b001, lat, obs, ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (!ok || obs !== exp) begin bad++; $display("FAIL single_nonprio_sb: got %h ok=%0d want %h", obs, ok, exp); end
        accept_rsp(0);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL single_then_both: got %b want 10", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_illegal_op();
        int lat; logic [37:0] obs, exp; bit ok;
        logic [2:0] exp_ctrl; int exp_lat; logic exp_err;
        run_op(0, 32'd1, 32'd2, 3'b011, lat, obs, ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (!ok || obs !== exp) begin bad++; $display("FAIL ill_pre_sb: got %h want %h", obs, exp); end
        accept_rsp(0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        exp_ctrl = 3'b011; exp_lat = 1; exp_err = 1'b1;
`else
        exp_ctrl = 3'b111; exp_lat = 2; exp_err = 1'b0;
`endif
        run_op(0, 32'd9, 32'd4, 3'b111, lat, obs, ok);
        total++; if (!ok || lat != exp_lat) begin bad++; $display("FAIL ill_latency: got %0d want %0d", lat, exp_lat); end
        total++; if (obs !== {1'b0, exp_err, 4'b1000, 32'd0}) begin bad++; $display("FAIL ill_result: got %h want %h", obs, {1'b0, exp_err, 4'b1000, 32'd0}); end
        total++; if (alu_ctrl !== exp_ctrl) begin bad++; $display("FAIL ill_alu_ctrl: got %b want %b", alu_ctrl, exp_ctrl); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (obs !== exp) begin bad++; $display("FAIL ill_sb: got %h want %h", obs, exp); end
        accept_rsp(0);
    endtask

    task automatic test_back_to_back();
        int lat; logic [37:0] obs, exp; bit ok;
        int ch; logic [31:0] a, b; logic [2:0] op;
        for (int n = 0; n < 16; n++) begin
            ch = int'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
            op = 3'($urandom_range(0, 7));
            run_op(ch, a, b, op, lat, obs, ok);
            total++; if (!ok || lat != exp_latency(op)) begin bad++; $display("FAIL b2b_latency: op %0d got %0d want %0d", n, lat, exp_latency(op)); end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            total++; if (obs !== exp) begin bad++; $display("FAIL b2b_sb: op %0d got %h want %h", n, obs, exp); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept_rsp(ch);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add_basic();
        test_sub_flags();
        test_overflow();
        test_round_robin();
        test_stall_reset();
        test_single_prio();
        test_illegal_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
